// File: rtl/jtopl_cpu_if_if.sv
// Host/chip bundle for jtopl_cpu_if.
//  master: sequencer/CPU side plus the chip's read-back data (drives cmd_*, stat_req, opl_dout)
//  slave : the jtopl_cpu_if initiator (drives cmd_ready, stat_vld, status, busy, opl_* strobes)
interface jtopl_cpu_if_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_reg;
    logic [7:0] cmd_val;
    logic       stat_req;
    logic       stat_vld;
    logic [7:0] status;
    logic       busy;
    logic [7:0] opl_din;
    logic       opl_addr;
    logic       opl_cs_n;
    logic       opl_wr_n;
    logic [7:0] opl_dout;

    modport master (
        output cmd_valid, cmd_reg, cmd_val, stat_req, opl_dout,
        input  cmd_ready, stat_vld, status, busy,
        input  opl_din, opl_addr, opl_cs_n, opl_wr_n
    );

    modport slave (
        input  cmd_valid, cmd_reg, cmd_val, stat_req, opl_dout,
        output cmd_ready, stat_vld, status, busy,
        output opl_din, opl_addr, opl_cs_n, opl_wr_n
    );
endinterface

// File: rtl/jtopl_cpu_if.sv
// jtopl_cpu_if: host-side bus initiator for the OPL CPU port.
//  Register writes are queued in a small FIFO and replayed as an address strobe
//  and a data strobe, each followed by the chip's mandatory idle time. Status
//  reads are merged into a single pending request that beats queued writes.
// Ports:
//  clk  system clock
//  rst  synchronous reset, active high
//  cen  chip clock enable (same enable as jtopl); FSM advances only when high
//  bus  slave view: command FIFO input, status read-back, busy, OPL strobes
module jtopl_cpu_if #(
    parameter int unsigned FIFO_AW   = 2,
    parameter int unsigned ADDR_WAIT = 12,
    parameter int unsigned DATA_WAIT = 84
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cen,
    jtopl_cpu_if_if.slave        bus
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned WMAX  = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
    localparam int unsigned CW    = $clog2(WMAX + 1);

    typedef struct packed {
        logic [7:0] idx;
        logic [7:0] val;
    } cmd_t;

    typedef enum logic [2:0] {IDLE, ADR, AWAIT, DAT, DWAIT, RD} state_t;

    cmd_t               mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               full, empty, push, pop;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [7:0]         cur_val;
    logic               rd_pend;
    logic               cs_n, wr_n, addr, stat_vld;
    logic [7:0]         din, status;

    assign full  = (count == (FIFO_AW+1)'(DEPTH));
    assign empty = (count == '0);
    // push is blocked while full even if a pop happens in the same cycle
    assign push  = bus.cmd_valid && !full;
    assign pop   = cen && (state == IDLE) && !rd_pend && !empty;

    // FIFO storage, no reset needed: validity is tracked by count
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{idx: bus.cmd_reg, val: bus.cmd_val};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (FIFO_AW+1)'(1);
                2'b01:   count <= count - (FIFO_AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Access sequencer with registered bus strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            cur_val  <= '0;
            rd_pend  <= 1'b0;
            cs_n     <= 1'b1;
            wr_n     <= 1'b1;
            addr     <= 1'b0;
            din      <= '0;
            status   <= '0;
            stat_vld <= 1'b0;
        end else begin
            stat_vld <= 1'b0;
            if (cen) begin
                case (state)
                    IDLE: begin
                        if (rd_pend) begin
                            state <= RD;
                            cs_n  <= 1'b0;
                            wr_n  <= 1'b1;
                            addr  <= 1'b0;
                        end else if (!empty) begin
                            state   <= ADR;
                            cur_val <= mem[rd_ptr].val;
                            din     <= mem[rd_ptr].idx;
                            cs_n    <= 1'b0;
                            wr_n    <= 1'b0;
                            addr    <= 1'b0;
                        end
                    end
                    ADR: begin
                        state <= AWAIT;
                        cs_n  <= 1'b1;
                        wr_n  <= 1'b1;
                        cnt   <= CW'(ADDR_WAIT - 1);
                    end
                    AWAIT: begin
                        if (cnt == '0) begin
                            state <= DAT;
                            cs_n  <= 1'b0;
                            wr_n  <= 1'b0;
                            addr  <= 1'b1;
                            din   <= cur_val;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    DAT: begin
                        state <= DWAIT;
                        cs_n  <= 1'b1;
                        wr_n  <= 1'b1;
                        cnt   <= CW'(DATA_WAIT - 1);
                    end
                    DWAIT: begin
                        if (cnt == '0) state <= IDLE;
                        else           cnt   <= cnt - CW'(1);
                    end
                    RD: begin
                        state    <= IDLE;
                        cs_n     <= 1'b1;
                        status   <= bus.opl_dout;
                        stat_vld <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        cs_n  <= 1'b1;
                        wr_n  <= 1'b1;
                    end
                endcase
            end
            // a request landing on the RD exit edge wins over the clear
            if (cen && (state == RD)) rd_pend <= 1'b0;
            if (bus.stat_req)         rd_pend <= 1'b1;
        end
    end

    assign bus.cmd_ready = !full;
    assign bus.busy      = (state != IDLE) || !empty || rd_pend;
    assign bus.stat_vld  = stat_vld;
    assign bus.status    = status;
    assign bus.opl_din   = din;
    assign bus.opl_addr  = addr;
    assign bus.opl_cs_n  = cs_n;
    assign bus.opl_wr_n  = wr_n;
endmodule

// File: tb/tb_jtopl_cpu_if.sv
// Testbench for jtopl_cpu_if: directed stimulus, expected bus strobes and status
// bytes are queued at issue time and popped by an independent bus monitor.
module tb_jtopl_cpu_if;
    localparam int K_ADR = 0;
    localparam int K_DAT = 1;
    localparam int K_RD  = 2;

    typedef struct {
        int         kind;
        logic [7:0] din;
        logic       addr;
        int         gap;   // clks since previous strobe start, -1 = not checked
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cen = 1'b0;

    jtopl_cpu_if_if bus();

    jtopl_cpu_if #(
        .FIFO_AW  (2),
        .ADDR_WAIT(12),
        .DATA_WAIT(84)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cen(cen),
        .bus(bus)
    );

    always #5 clk = ~clk;

    exp_t       expq[$];
    logic [7:0] statq[$];
    int compares   = 0;
    int errors     = 0;
    int cyc        = 0;
    int div        = 1;   // 0 = cen held low, n = cen every n-th clk
    int phase      = 0;
    int strobes    = 0;
    int rds        = 0;
    int vlds       = 0;
    int last_start = 0;
    logic prev_cs  = 1'b1;
    int low_w      = 0;
    int vld_w      = 0;

    always @(posedge clk) cyc++;

    // cen generator
    always @(negedge clk) begin
        if (div == 0) begin
            cen = 1'b0;
        end else begin
            cen   = (phase == 0);
            phase = (phase + 1) % div;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compares++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        compares++;
        errors++;
        $display("FAIL %s: DUT output with nothing expected (cyc %0d)", name, cyc);
    endtask

    // Monitor: strobe starts, strobe widths and status pulses
    always @(negedge clk) begin
        int   kind;
        exp_t e;
        if (bus.opl_cs_n == 1'b0 && prev_cs == 1'b1) begin
            strobes++;
            kind = bus.opl_wr_n ? K_RD : (bus.opl_addr ? K_DAT : K_ADR);
            if (kind == K_RD) rds++;
            if (expq.size() == 0) begin
                unexpected("strobe");
            end else begin
                e = expq.pop_front();
                check("strobe_kind", kind, e.kind);
                check("strobe_din", {24'd0, bus.opl_din}, {24'd0, e.din});
                check("strobe_addr", {31'd0, bus.opl_addr}, {31'd0, e.addr});
                if (e.gap >= 0) check("strobe_gap", cyc - last_start, e.gap);
            end
            last_start = cyc;
            low_w      = 1;
        end else if (bus.opl_cs_n == 1'b0) begin
            low_w++;
        end else if (prev_cs == 1'b0) begin
            check("strobe_width", low_w, div);
        end
        prev_cs = bus.opl_cs_n;

        if (bus.stat_vld) begin
            vld_w++;
            if (vld_w == 1) begin
                vlds++;
                if (statq.size() == 0) unexpected("stat_vld");
                else check("status", {24'd0, bus.status}, {24'd0, statq.pop_front()});
            end
        end else if (vld_w > 0) begin
            check("stat_vld_width", vld_w, 1);
            vld_w = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_strobe(input int kind, input logic [7:0] d, input logic a, input int gap);
        exp_t e;
        e.kind = kind;
        e.din  = d;
        e.addr = a;
        e.gap  = gap;
        expq.push_back(e);
    endtask

    task automatic expect_write(input logic [7:0] r, input logic [7:0] v, input int ga, input int gd);
        expect_strobe(K_ADR, r, 1'b0, ga);
        expect_strobe(K_DAT, v, 1'b1, gd);
    endtask

    // Drive one write command and hold it until accepted
    task automatic push(input logic [7:0] r, input logic [7:0] v);
        int n = 0;
        bus.cmd_reg   = r;
        bus.cmd_val   = v;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) unexpected("push_timeout");
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic pulse_stat;
        bus.stat_req = 1'b1;
        @(negedge clk);
        bus.stat_req = 1'b0;
    endtask

    task automatic wait_strobes(input int target);
        int n = 0;
        while (strobes < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("wait_strobes_timeout", {31'd0, n >= 3000}, 0);
    endtask

    task automatic wait_idle;
        int n = 0;
        while ((bus.busy || expq.size() != 0 || statq.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", {31'd0, n >= 5000}, 0);
        tick(2);
    endtask

    initial begin
        int s0;
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_reg   = 8'h00;
        bus.cmd_val   = 8'h00;
        bus.stat_req  = 1'b0;
        bus.opl_dout  = 8'h00;

        // reset state
        tick(3);
        check("rst_cs_n", {31'd0, bus.opl_cs_n}, 1);
        check("rst_wr_n", {31'd0, bus.opl_wr_n}, 1);
        check("rst_addr", {31'd0, bus.opl_addr}, 0);
        check("rst_din", {24'd0, bus.opl_din}, 0);
        check("rst_status", {24'd0, bus.status}, 0);
        check("rst_stat_vld", {31'd0, bus.stat_vld}, 0);
        check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 1);
        check("rst_busy", {31'd0, bus.busy}, 0);
        rst = 1'b0;
        tick(2);

        // single write, full-rate cen; busy drops 85 clks after the data strobe
        expect_write(8'h20, 8'h01, -1, 13);
        push(8'h20, 8'h01);
        n = 0;
        while (bus.busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("busy_low_after_dat", cyc - last_start, 85);
        wait_idle();

        // fill the FIFO with cen frozen, fifth write waits for the first pop
        div = 0;
        tick(2);
        expect_write(8'h30, 8'h11, -1, 13);
        push(8'h30, 8'h11);
        expect_write(8'h31, 8'h12, 86, 13);
        push(8'h31, 8'h12);
        expect_write(8'h32, 8'h13, 86, 13);
        push(8'h32, 8'h13);
        expect_write(8'h33, 8'h14, 86, 13);
        push(8'h33, 8'h14);
        check("full_cmd_ready", {31'd0, bus.cmd_ready}, 0);
        expect_write(8'h34, 8'h15, 86, 13);
        bus.cmd_reg   = 8'h34;
        bus.cmd_val   = 8'h15;
        bus.cmd_valid = 1'b1;
        tick(3);
        check("full_hold_ready", {31'd0, bus.cmd_ready}, 0);
        check("full_hold_busy", {31'd0, bus.busy}, 1);
        div = 1;
        push(8'h34, 8'h15);
        wait_idle();

        // status read requested during DWAIT beats a queued write
        bus.opl_dout = 8'hE0;
        s0 = strobes;
        expect_write(8'h61, 8'h7F, -1, 13);
        push(8'h61, 8'h7F);
        wait_strobes(s0 + 2);
        tick(20);
        expect_strobe(K_RD, 8'h7F, 1'b0, 86);
        statq.push_back(8'hE0);
        pulse_stat();
        expect_write(8'h62, 8'h33, 2, 13);
        push(8'h62, 8'h33);
        wait_idle();
        check("status_hold", {24'd0, bus.status}, 8'hE0);

        // slow cen: strobes span 4 clks and waits scale by 4
        div = 4;
        tick(4);
        expect_write(8'hA0, 8'h55, -1, 52);
        push(8'hA0, 8'h55);
        expect_write(8'hB0, 8'h66, 344, 52);
        push(8'hB0, 8'h66);
        wait_idle();

        // reset during AWAIT aborts the access
        div = 1;
        tick(2);
        s0 = strobes;
        expect_strobe(K_ADR, 8'h40, 1'b0, -1);
        push(8'h40, 8'h11);
        wait_strobes(s0 + 1);
        tick(4);
        rst = 1'b1;
        tick(1);
        check("abort_cs_n", {31'd0, bus.opl_cs_n}, 1);
        check("abort_busy", {31'd0, bus.busy}, 0);
        check("abort_cmd_ready", {31'd0, bus.cmd_ready}, 1);
        rst = 1'b0;
        s0 = strobes;
        tick(30);
        check("abort_no_dat", strobes, s0);

        // two requests before the read merge into one
        div = 0;
        tick(2);
        bus.opl_dout = 8'h3C;
        s0 = rds;
        n  = vlds;
        expect_strobe(K_RD, 8'h00, 1'b0, -1);
        statq.push_back(8'h3C);
        pulse_stat();
        tick(1);
        pulse_stat();
        check("merge_busy", {31'd0, bus.busy}, 1);
        div = 1;
        wait_idle();
        tick(10);
        check("merge_rd_count", rds - s0, 1);
        check("merge_vld_count", vlds - n, 1);

        check("expq_empty", expq.size(), 0);
        check("statq_empty", statq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
        $fatal(1);
    end
endmodule
